pe_mac_multi: RTL and testbench
===============================

Name: pe_mac_multi

Overview:
Parametrised successor to the single-lane PE. Holds a NUM_DATA-tap filter for each of NUM_LANES lanes. One shared input stream B is broadcast to all lanes, and every lane multiply-accumulates over a runtime-selectable window length. Additions over the single-lane PE: valid/ready handshakes on input and output, signed/unsigned mode, and output backpressure. Sits between the input-feature buffer and the output/partial-sum collector.

Parameters:
FILTER_WIDTH, 8, weight width
INPUT_WIDTH, 8, input sample width
PE_OUT_WIDTH, 24, accumulator/result width per lane; must be >= FILTER_WIDTH+INPUT_WIDTH
NUM_DATA, 16, maximum taps per window
NUM_LANES, 4, parallel filters sharing B

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
Aload  in  1  load weights/config pulse
A  in  FILTER_WIDTH*NUM_DATA*NUM_LANES  weights; lane l, tap k at A[(l*NUM_DATA+k)*FILTER_WIDTH +: FILTER_WIDTH]
k_len  in  $clog2(NUM_DATA+1)  window length, sampled on Aload
signed_mode  in  1  1 = two's-complement operands, sampled on Aload
in_valid  in  1  B beat valid
in_ready  out  1  PE accepts B beat
B  in  INPUT_WIDTH  input sample
out_valid  out  1  Y holds completed window
out_ready  in  1  consumer accepts Y
Y  out  PE_OUT_WIDTH*NUM_LANES  lane l result at Y[l*PE_OUT_WIDTH +: PE_OUT_WIDTH]
sat  out  NUM_LANES  per-lane saturation-occurred flag (see Optional Feature)

Behaviour:
- Reset (reset_n low, async):
  - State IDLE.
  - Y, sat, accumulators, tap index and weights all cleared to 0.
  - out_valid=0, in_ready=0.
  - Reset mid-window discards the window.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: no weights loaded. in_ready=0. B beats are ignored.
  - Aload=1 in any state:
    - Latches A, signed_mode and k_len.
    - k_len==0 or k_len>NUM_DATA is clamped to NUM_DATA.
    - Clears accumulators, tap index, out_valid and sat.
    - Next state RUN.
    - Aload has priority over everything in that cycle. in_ready is forced to 0 while Aload=1, so no beat is accepted that cycle.
  - RUN: in_ready=1 (unless Aload).
    - On in_valid&&in_ready: acc[l] <= acc[l] + W[l][idx]*B for every lane; idx <= idx+1.
    - The first accepted beat after Aload or after a result handoff uses tap 0.
    - On the beat with idx==len-1: Y <= the final sums (the registered result includes this beat), idx <= 0, next state HOLD.
  - HOLD: out_valid=1, in_ready=0.
    - Y and sat stay stable until out_valid&&out_ready.
    - On handoff: accumulators and sat cleared; weights, len and mode retained; next state RUN.
- Latency and throughput:
  - out_valid rises the cycle after the last beat of the window is accepted.
  - Peak rate is one window per len+1 cycles when out_ready is tied high.
- Arithmetic:
  - signed_mode=0: both operands zero-extended.
  - signed_mode=1: both operands sign-extended; the product is sign-extended to PE_OUT_WIDTH.
  - Without SAT_EN, sums wrap mod 2^PE_OUT_WIDTH.
- Stalls: in_valid low leaves accumulators and idx unchanged, with no timeout.

Optional Feature:
Macro PE_MAC_SAT_EN.
- Defined: each lane's add saturates.
  - Unsigned mode: to 2^PE_OUT_WIDTH-1.
  - Signed mode: to +/-(2^(PE_OUT_WIDTH-1)) bounds.
  - sat[l] is sticky for the window and is set when any add in lane l clipped.
- Undefined: sums wrap and sat is tied to 0. The port list is identical in both builds.

Decomposition:
- Package pe_pkg: FSM state enum (PE_IDLE, PE_RUN, PE_HOLD), shared width parameters, and a function computing the lane/tap slice offset.
- Sub-module pe_mac_lane: one lane's weight register file, tap mux, multiplier, accumulator and saturation logic. Instantiated NUM_LANES times via generate. The FSM, index counter and handshake live in the top.

Test Plan:
- Basic unsigned window: all weights 0x11, k_len=16, signed_mode=0, B=0x01 with in_valid held high, out_ready=1 -> out_valid one cycle after the 16th beat; every lane Y=0x000110.
- Signed window: weights 0xFF (-1), k_len=4, signed_mode=1, B=0x02 -> Y=0xFFFFF8 on all lanes.
- Per-lane distinct weights: lane l all taps = l+1, B=0x03, k_len=2 -> Y lanes 0..3 = 0x6, 0xC, 0x12, 0x18.
- Backpressure: out_ready held low 5 cycles after out_valid -> in_ready=0, Y constant; on handshake the next window's results start from 0.
- Aload mid-window: after 7 of 16 beats, pulse Aload with k_len=3 while in_valid=1 -> the beat in the Aload cycle is not accepted; the next result is the sum of only 3 new beats.
- Overflow (PE_OUT_WIDTH=16): unsigned, weights 0xFF, B=0xFF, k_len=16 -> Y=0xE010 and sat=0 without PE_MAC_SAT_EN; Y=0xFFFF and sat=1 with it.
- Async reset mid-window: assert reset_n low between clock edges -> outputs clear immediately; in_ready stays 0 until Aload.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM state, default widths and weight slice helper
// for pe_mac_multi. Optional saturation build: PE_MAC_SAT_EN.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_IDLE = 2'd0,
    PE_RUN  = 2'd1,
    PE_HOLD = 2'd2
  } pe_state_e;

  localparam int FILTER_WIDTH_D = 8;
  localparam int INPUT_WIDTH_D  = 8;
  localparam int PE_OUT_WIDTH_D = 24;
  localparam int NUM_DATA_D     = 16;
  localparam int NUM_LANES_D    = 4;

  function automatic int pe_off(
    input int lane,
    input int tap,
    input int nd,
    input int fw
  );
    return (lane * nd + tap) * fw;
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// pe_mac_lane: one lane's weights, tap mux, multiplier and accumulator.
// PE_MAC_SAT_EN selects saturating adds with a sticky clip flag.
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int FW = 8,
  parameter int IW = 8,
  parameter int OW = 24,
  parameter int ND = 16,
  parameter int XW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic [FW*ND-1:0] i_w,
  input  logic           i_mode,
  input  logic [XW-1:0]  i_idx,
  input  logic [IW-1:0]  i_b,
  input  logic           i_beat,
  input  logic           i_last,
  input  logic           i_clr,
  output logic [OW-1:0]  o_y,
  output logic           o_sat
);

`ifdef PE_MAC_SAT_EN
  // Two guard bits keep the exact sum for clip detection.
  localparam int SW = OW + 2;
  localparam logic signed [SW-1:0] UMAX = SW'({OW{1'b1}});
  localparam logic signed [SW-1:0] SMAX = SW'({(OW-1){1'b1}});
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
`else
  localparam int SW = OW;
`endif

  logic [FW*ND-1:0]      r_wts;
  logic [OW-1:0]         r_acc;
  logic [OW-1:0]         r_y;
  logic [FW-1:0]         w_w;
  logic signed [FW:0]    w_wx;
  logic signed [IW:0]    w_bx;
  logic signed [SW-1:0]  w_pe;
  logic signed [SW-1:0]  w_ax;
  logic signed [SW-1:0]  w_sum;
  logic [OW-1:0]         w_next;
  logic                  w_clip;

  assign w_w  = r_wts[pe_off(0, int'(i_idx), ND, FW) +: FW];
  assign w_wx = {i_mode & w_w[FW-1], w_w};
  assign w_bx = {i_mode & i_b[IW-1], i_b};
  assign w_pe = SW'(w_wx) * SW'(w_bx);

  always_comb begin
    if (i_mode) w_ax = SW'($signed(r_acc));
    else        w_ax = SW'($unsigned(r_acc));
    w_sum  = w_ax + w_pe;
    w_next = w_sum[OW-1:0];
    w_clip = 1'b0;
`ifdef PE_MAC_SAT_EN
    if (!i_mode) begin
      if (w_sum > UMAX) begin
        w_next = UMAX[OW-1:0];
        w_clip = 1'b1;
      end
    end else if (w_sum > SMAX) begin
      w_next = SMAX[OW-1:0];
      w_clip = 1'b1;
    end else if (w_sum < SMIN) begin
      w_next = SMIN[OW-1:0];
      w_clip = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wts <= '0;
      r_acc <= '0;
      r_y   <= '0;
    end else if (i_load) begin
      r_wts <= i_w;
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_beat) begin
      r_acc <= w_next;
      if (i_last) r_y <= w_next;
    end
  end

`ifdef PE_MAC_SAT_EN
  logic r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_sat <= 1'b0;
    else if (i_load || i_clr)  r_sat <= 1'b0;
    else if (i_beat && w_clip) r_sat <= 1'b1;
  end

  assign o_sat = r_sat;
`else
  assign o_sat = w_clip;
`endif

  assign o_y = r_y;

endmodule

// File: rtl/pe_mac_multi.sv
// pe_mac_multi: NUM_LANES MAC filters sharing one B stream, valid/ready
// on both sides. Build with PE_MAC_SAT_EN for saturating accumulation.
module pe_mac_multi
  import pe_pkg::*;
#(
  parameter int FILTER_WIDTH = FILTER_WIDTH_D,
  parameter int INPUT_WIDTH  = INPUT_WIDTH_D,
  parameter int PE_OUT_WIDTH = PE_OUT_WIDTH_D,
  parameter int NUM_DATA     = NUM_DATA_D,
  parameter int NUM_LANES    = NUM_LANES_D
) (
  input  logic clk,
  input  logic reset_n,
  input  logic Aload,
  input  logic [FILTER_WIDTH*NUM_DATA*NUM_LANES-1:0] A,
  input  logic [$clog2(NUM_DATA+1)-1:0] k_len,
  input  logic signed_mode,
  input  logic in_valid,
  output logic in_ready,
  input  logic [INPUT_WIDTH-1:0] B,
  output logic out_valid,
  input  logic out_ready,
  output logic [PE_OUT_WIDTH*NUM_LANES-1:0] Y,
  output logic [NUM_LANES-1:0] sat
);

  localparam int KW = $clog2(NUM_DATA + 1);
  localparam logic [KW-1:0] MAXK = KW'(NUM_DATA);

  pe_state_e     r_state;
  logic [KW-1:0] r_len;
  logic [KW-1:0] r_idx;
  logic          r_mode;
  logic [KW-1:0] w_klen;
  logic          w_beat;
  logic          w_last;
  logic          w_hs;

  assign w_klen = (k_len == '0 || k_len > MAXK) ? MAXK : k_len;

  assign in_ready  = (r_state == PE_RUN) && !Aload;
  assign out_valid = (r_state == PE_HOLD);
  assign w_beat    = in_valid && in_ready;
  assign w_last    = w_beat && (r_idx == r_len - KW'(1));
  assign w_hs      = out_valid && out_ready && !Aload;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PE_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_mode  <= 1'b0;
    end else if (Aload) begin
      r_state <= PE_RUN;
      r_len   <= w_klen;
      r_idx   <= '0;
      r_mode  <= signed_mode;
    end else begin
      case (r_state)
        PE_RUN: begin
          if (w_last) begin
            r_idx   <= '0;
            r_state <= PE_HOLD;
          end else if (w_beat) begin
            r_idx <= r_idx + KW'(1);
          end
        end
        PE_HOLD: if (w_hs) r_state <= PE_RUN;
        default: ;
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pe_mac_lane #(
      .FW (FILTER_WIDTH),
      .IW (INPUT_WIDTH),
      .OW (PE_OUT_WIDTH),
      .ND (NUM_DATA),
      .XW (KW)
    ) u_lane (
      .clk    (clk),
      .rst_n  (reset_n),
      .i_load (Aload),
      .i_w    (A[pe_off(l, 0, NUM_DATA, FILTER_WIDTH) +: FILTER_WIDTH*NUM_DATA]),
      .i_mode (r_mode),
      .i_idx  (r_idx),
      .i_b    (B),
      .i_beat (w_beat),
      .i_last (w_last),
      .i_clr  (w_hs),
      .o_y    (Y[l*PE_OUT_WIDTH +: PE_OUT_WIDTH]),
      .o_sat  (sat[l])
    );
  end

endmodule

// File: tb/tb_pe_mac_multi.sv
// tb_pe_mac_multi: directed checks of pe_mac_multi, default 4-lane
// instance plus a 16-bit single-lane instance for overflow cases.
module tb_pe_mac_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         Aload;
  logic [511:0] A;
  logic [4:0]   k_len;
  logic         signed_mode;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   B;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  Y;
  logic [3:0]   sat;

  logic         Aload16;
  logic [127:0] A16;
  logic [4:0]   k_len16;
  logic         sm16;
  logic         iv16;
  logic         ir16;
  logic [7:0]   B16;
  logic         ov16;
  logic         or16;
  logic [15:0]  Y16;
  logic [0:0]   sat16;

  int checks = 0;
  int errors = 0;

  pe_mac_multi u_dut (
    .clk(clk), .reset_n(reset_n), .Aload(Aload), .A(A),
    .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .sat(sat)
  );

  pe_mac_multi #(
    .PE_OUT_WIDTH(16), .NUM_LANES(1)
  ) u_dut16 (
    .clk(clk), .reset_n(reset_n), .Aload(Aload16), .A(A16),
    .k_len(k_len16), .signed_mode(sm16),
    .in_valid(iv16), .in_ready(ir16), .B(B16),
    .out_valid(ov16), .out_ready(or16),
    .Y(Y16), .sat(sat16)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_w(input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 16; k++)
        A[(l*16+k)*8 +: 8] = w[l];
  endtask

  task automatic load(input logic [4:0] k, input logic m);
    k_len = k;
    signed_mode = m;
    Aload = 1'b1;
    #1;
    chk("in_ready_during_aload", in_ready, 1'b0);
    @(negedge clk);
    Aload = 1'b0;
  endtask

  task automatic run(input int n, input logic [7:0] b);
    B = b;
    in_valid = 1'b1;
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; Aload = 1'b0; A = '0; k_len = '0;
    signed_mode = 1'b0; in_valid = 1'b0; B = '0; out_ready = 1'b1;
    Aload16 = 1'b0; A16 = '0; k_len16 = '0; sm16 = 1'b0;
    iv16 = 1'b0; B16 = '0; or16 = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_y", Y, 96'h0);
    chk("rst_sat", sat, 4'h0);

    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1; B = 8'h05;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b0);
    chk("idle_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;

    // basic unsigned 16-tap window
    set_w(8'h11, 8'h11, 8'h11, 8'h11);
    load(5'd16, 1'b0);
    run(15, 8'h01);
    chk("t1_early", out_valid, 1'b0);
    run(1, 8'h01);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_y", Y, {4{24'h000110}});
    chk("t1_sat", sat, 4'h0);

    set_w(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    load(5'd4, 1'b1);
    run(4, 8'h02);
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_y_signed", Y, {4{24'hFFFFF8}});

    set_w(8'h01, 8'h02, 8'h03, 8'h04);
    load(5'd2, 1'b0);
    run(2, 8'h03);
    chk("t3_y_lanes", Y, {24'h18, 24'h12, 24'h0C, 24'h06});

    // consumer stalls for 5 cycles with B still offered
    out_ready = 1'b0;
    B = 8'h07; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_y_stable", Y, {24'h18, 24'h12, 24'h0C, 24'h06});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_valid", out_valid, 1'b0);
    chk("bp_after_hs_ready", in_ready, 1'b1);
    run(2, 8'h02);
    chk("bp_next_from_zero", Y, {24'h10, 24'h0C, 24'h08, 24'h04});

    set_w(8'h11, 8'h11, 8'h11, 8'h11);
    load(5'd0, 1'b0);
    run(15, 8'h01);
    chk("klen0_early", out_valid, 1'b0);
    run(1, 8'h01);
    chk("klen0_valid", out_valid, 1'b1);
    chk("klen0_y", Y, {4{24'h000110}});

    load(5'd20, 1'b0);
    run(15, 8'h02);
    chk("klen20_early", out_valid, 1'b0);
    run(1, 8'h02);
    chk("klen20_valid", out_valid, 1'b1);
    chk("klen20_y", Y, {4{24'h000220}});

    // reload after 7 of 16 beats; the Aload-cycle beat must be dropped
    load(5'd16, 1'b0);
    run(7, 8'h01);
    chk("mid_no_valid", out_valid, 1'b0);
    B = 8'h10; in_valid = 1'b1;
    load(5'd3, 1'b0);
    run(2, 8'h01);
    chk("mid_early", out_valid, 1'b0);
    run(1, 8'h01);
    chk("mid_valid", out_valid, 1'b1);
    chk("mid_y", Y, {4{24'h000033}});

    // 16-bit accumulator overflow
    for (int k = 0; k < 16; k++) A16[k*8 +: 8] = 8'hFF;
    k_len16 = 5'd16; sm16 = 1'b0; Aload16 = 1'b1;
    @(negedge clk);
    Aload16 = 1'b0;
    B16 = 8'hFF; iv16 = 1'b1;
    repeat (16) @(negedge clk);
    iv16 = 1'b0;
    chk("ovf_valid", ov16, 1'b1);
`ifdef PE_MAC_SAT_EN
    chk("ovf_y", Y16, 16'hFFFF);
    chk("ovf_sat", sat16, 1'b1);
`else
    chk("ovf_y", Y16, 16'hE010);
    chk("ovf_sat", sat16, 1'b0);
`endif

    // async reset mid-window, between clock edges
    load(5'd16, 1'b0);
    B = 8'h01; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_y", Y, 96'h0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_sat", sat, 4'h0);
    chk("arst_y16", Y16, 16'h0);
    chk("arst_sat16", sat16, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_idle_ready", in_ready, 1'b0);
    chk("arst_idle_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    set_w(8'h01, 8'h02, 8'h03, 8'h04);
    load(5'd2, 1'b0);
    run(2, 8'h01);
    chk("arst_recover_y", Y, {24'h08, 24'h06, 24'h04, 24'h02});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
